// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first one CHUNK per cycle,
// stops at the first differing chunk, and returns gt/eq/lt plus the cycles used.
`timescale 1ns/1ps
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic                            is_signed,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            gt,
    output logic                            eq,
    output logic                            lt,
    output logic [$clog2(WIDTH/CHUNK):0]    cycles
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH) + 1;

    localparam logic [CW-1:0]    LAST_IDX = CW'(NCH - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_magnitude_comparator: CHUNK must divide WIDTH exactly");
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [WIDTH-1:0] bias_msb(input logic [WIDTH-1:0] v, input logic s);
        return v ^ ({WIDTH{s}} & MSB_MASK);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;

    // Operands are shifted left after each equal chunk, so the live chunk is always the top one.
    assign chunk_a = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b = b_q[WIDTH-1 -: CHUNK];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = bias_msb(a, is_signed);
                    b_d     = bias_msb(b, is_signed);
                    idx_d   = '0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (chunk_a != chunk_b) begin
                    gt_d     = chunk_a > chunk_b;
                    lt_d     = chunk_a < chunk_b;
                    eq_d     = 1'b0;
                    cycles_d = idx_q + CW'(1);
                    state_d  = S_DONE;
                end else if (idx_q == LAST_IDX) begin
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b1;
                    cycles_d = CW'(NCH);
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + CW'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
            end
            S_DONE: begin
                // Results are cleared on release so gt/eq/lt read 0 whenever out_valid is low.
                if (out_ready) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    cycles_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            cycles_q <= cycles_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        idx_q <= idx_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: a driver pushes model results,
// a negedge monitor pops and compares whenever a new result is presented.
`timescale 1ns/1ps
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CW    = $clog2(NCH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             is_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             gt, eq, lt;
    logic [CW-1:0]    cycles;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .gt(gt), .eq(eq), .lt(lt), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   gt;
        logic   eq;
        logic   lt;
        int     cyc;
        longint acc;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc_cnt = 0;
    bit     force_low = 1'b0;
    bit     rand_rdy = 1'b0;
    bit     mon_en = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: ordering from plain integer compare; cycles from the position of the
    // most significant differing bit (the sign bias never moves where operands differ).
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        exp_t e;
        longint xv, yv;
        logic [WIDTH-1:0] diff;
        int p;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        e.gt = (xv > yv);
        e.eq = (xv == yv);
        e.lt = (xv < yv);
        diff = x ^ y;
        p = -1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (p < 0 && diff[i]) p = i;
        end
        e.cyc = (p < 0) ? NCH : ((WIDTH - 1 - p) / CHUNK + 1);
        e.acc = 0;
        return e;
    endfunction

    // out_ready driver, 2 time units after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (force_low)     out_ready = 1'b0;
            else if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            else               out_ready = 1'b1;
        end
    end

    // Monitor
    bit            prev_ov = 1'b0;
    bit            prev_hs = 1'b0;
    logic [2:0]    h_res;
    logic [CW-1:0] h_cyc;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (!out_valid) chk("idle_results_zero", {61'd0, gt, eq, lt}, 64'd0);
            if (prev_hs)    chk("out_valid_drop_after_accept", {63'd0, out_valid}, 64'd0);
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("gt", {63'd0, gt}, {63'd0, e.gt});
                    chk("eq", {63'd0, eq}, {63'd0, e.eq});
                    chk("lt", {63'd0, lt}, {63'd0, e.lt});
                    chk("cycles", {{(64-CW){1'b0}}, cycles}, 64'(e.cyc));
                    chk("latency", 64'(cyc_cnt - e.acc), 64'(e.cyc));
                end
                h_res = {gt, eq, lt};
                h_cyc = cycles;
            end else if (out_valid && prev_ov) begin
                chk("held_results", {61'd0, gt, eq, lt}, {61'd0, h_res});
                chk("held_cycles", {{(64-CW){1'b0}}, cycles}, {{(64-CW){1'b0}}, h_cyc});
                chk("in_ready_while_done", {63'd0, in_ready}, 64'd0);
            end
            prev_hs = out_valid && out_ready;
            prev_ov = out_valid;
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        exp_t e;
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        e = model(x, y, s);
        e.acc = cyc_cnt;
        sb.push_back(e);
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        if (sb.size() != 0 || out_valid) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] x, y;
        int w;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_results", {61'd0, gt, eq, lt}, 64'd0);
        chk("reset_cycles", {{(64-CW){1'b0}}, cycles}, 64'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        issue(32'd0, 32'd0, 1'b0);
        issue(32'h0000_305D, 32'h0000_2124, 1'b0);
        issue(32'h0000_2124, 32'h0000_305D, 1'b0);
        issue(-32'sd5, -32'sd6, 1'b1);
        issue(-32'sd6, -32'sd5, 1'b1);
        issue(-32'sd6, 32'd5, 1'b1);
        issue(32'hFFFF_FFFA, 32'd5, 1'b0);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        drain();

        // Backpressure: stall in DONE and try to sneak in a new operation
        force_low = 1'b1;
        issue(32'h0000_305D, 32'h0000_2124, 1'b0);
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("stall_reached_done", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            a = 32'h1111_1111; b = 32'h2222_2222; in_valid = (i == 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        force_low = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("stall_no_extra_capture", {63'd0, in_ready}, 64'd1);

        // Reset in the middle of a compare: nothing must come out
        a = '0; b = '0; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_results", {61'd0, gt, eq, lt}, 64'd0);
        chk("midrst_cycles", {{(64-CW){1'b0}}, cycles}, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        issue(32'h1234_5678, 32'h1234_5678, 1'b1);
        issue(32'h1234_5678, 32'h1234_5679, 1'b1);
        drain();

        // Randomized operations with random consumer backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = $urandom;
                1: y = x;
                2: y = x ^ (32'd1 << $urandom_range(0, WIDTH - 1));
                default: y = x ^ ($urandom & 32'h0000_00FF);
            endcase
            issue(x, y, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
